// File: rtl/sdp_fifo_pkg.sv
// rtl/sdp_fifo_pkg.sv - shared types and helpers for sdp_fifo_m
package sdp_fifo_pkg;

  localparam int DEPTH_DEF = 512;
  // Widest in-flight vector the popcount helper handles (RD_LATENCY max).
  localparam int VLD_MAX   = 4;

  typedef logic [$clog2(DEPTH_DEF)-1:0] ptr_t;

  function automatic logic [2:0] popcount(input logic [VLD_MAX-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < VLD_MAX; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/ram_sdp_m.sv
// rtl/ram_sdp_m.sv - simple dual-port RAM with pipelined read
module ram_sdp_m #(
  parameter int  MEM_SIZE     = 16384,
  parameter int  WR_DATA_W    = 32,
  parameter int  RD_DATA_W    = 32,
  parameter int  BYTE_WRITE_W = 32,
  parameter      MEM_TYPE     = "block",
  parameter int  RD_LATENCY   = 2,
  localparam int WORDS        = MEM_SIZE / WR_DATA_W,
  localparam int AW           = $clog2(WORDS),
  localparam int NBE          = WR_DATA_W / BYTE_WRITE_W
) (
  input  logic                 wr_clk,
  input  logic [NBE-1:0]       wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WR_DATA_W-1:0] wr_data,
  input  logic                 rd_clk,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [RD_DATA_W-1:0] rd_data
);

  // Block RAM output registers honour rd_en; other styles run free.
  localparam bit GATED = (MEM_TYPE == "block");

  logic [WR_DATA_W-1:0] mem_q  [WORDS];
  logic [RD_DATA_W-1:0] pipe_q [RD_LATENCY];

  // Byte-lane writes; contents are never cleared
  always_ff @(posedge wr_clk) begin
    for (int b = 0; b < NBE; b++) begin
      if (wr_en[b]) mem_q[wr_addr][b*BYTE_WRITE_W +: BYTE_WRITE_W] <= wr_data[b*BYTE_WRITE_W +: BYTE_WRITE_W];
    end
  end

  // Read pipeline: data appears RD_LATENCY edges after the address is sampled
  always_ff @(posedge rd_clk) begin
    if (rd_en || !GATED) begin
      pipe_q[0] <= mem_q[rd_addr];
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rd_data = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/sdp_fifo_ob_m.sv
// rtl/sdp_fifo_ob_m.sv - small register FIFO holding prefetched RAM words
module sdp_fifo_ob_m #(
  parameter int  DATA_W   = 32,
  parameter int  OB_DEPTH = 3,
  localparam int CW       = $clog2(OB_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     cnt
);

  logic [DATA_W-1:0] ent_q [OB_DEPTH];
  logic [DATA_W-1:0] ent_d [OB_DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d, wpos;

  // Head lives in entry 0; a pop shifts down, a write lands after the survivors
  always_comb begin
    ent_d = ent_q;
    wpos  = cnt_q - CW'(rd_en);
    if (rd_en) begin
      for (int i = 0; i < OB_DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
      ent_d[OB_DEPTH-1] = '0;
    end
    if (wr_en) begin
      for (int i = 0; i < OB_DEPTH; i++) begin
        if (CW'(i) == wpos) ent_d[i] = wr_data;
      end
    end
    cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
  end

  // Register the entries and fill level
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OB_DEPTH; i++) ent_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_data = ent_q[0];
  assign cnt     = cnt_q;

  ob_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !rd_en && cnt_q == CW'(OB_DEPTH)));

endmodule

// File: rtl/sdp_fifo_m.sv
// rtl/sdp_fifo_m.sv - synchronous FIFO with prefetching output buffer over ram_sdp_m
module sdp_fifo_m
  import sdp_fifo_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  DEPTH      = 512,
  parameter      MEM_TYPE   = "block",
  parameter int  RD_LATENCY = 2,
  localparam int OB_DEPTH   = RD_LATENCY + 1,
  localparam int CNT_W      = $clog2(DEPTH + OB_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(OB_DEPTH + 1);

  logic [AW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [MW-1:0]         mem_cnt_q, mem_cnt_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  rst_q;
  logic                  push, pop, issue;
  logic [2:0]            inflight;
  logic [OW-1:0]         ob_cnt;
  logic [DATA_W-1:0]     ram_rd_data;

  assign in_ready  = !rst_q && (mem_cnt_q != MW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign out_valid = (ob_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign inflight  = popcount(VLD_MAX'(vld_q));
  assign count     = count_q;

  // Issue a read only when the buffer has room for it once everything in flight lands
  always_comb begin
    issue     = (mem_cnt_q != '0) &&
                (int'(ob_cnt) + int'(inflight) - int'(pop) < OB_DEPTH);
    wp_d      = wp_q + AW'(push);
    rp_d      = rp_q + AW'(issue);
    mem_cnt_d = mem_cnt_q + MW'(push) - MW'(issue);
    vld_d     = (vld_q << 1) | RD_LATENCY'(issue);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers; clearing vld drops whatever the RAM pipeline still carries
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      mem_cnt_q <= '0;
      vld_q     <= '0;
      count_q   <= '0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      mem_cnt_q <= mem_cnt_d;
      vld_q     <= vld_d;
      count_q   <= count_d;
    end
  end

  ram_sdp_m #(
    .MEM_SIZE     (DEPTH * DATA_W),
    .WR_DATA_W    (DATA_W),
    .RD_DATA_W    (DATA_W),
    .BYTE_WRITE_W (DATA_W),
    .MEM_TYPE     (MEM_TYPE),
    .RD_LATENCY   (RD_LATENCY)
  ) u_ram (
    .wr_clk  (clk),
    .wr_en   (push),
    .wr_addr (wp_q),
    .wr_data (in_data),
    .rd_clk  (clk),
    .rd_en   (1'b1),
    .rd_addr (rp_q),
    .rd_data (ram_rd_data)
  );

  sdp_fifo_ob_m #(
    .DATA_W   (DATA_W),
    .OB_DEPTH (OB_DEPTH)
  ) u_ob (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_q[RD_LATENCY-1]),
    .wr_data (ram_rd_data),
    .rd_en   (pop),
    .rd_data (out_data),
    .cnt     (ob_cnt)
  );

endmodule

// File: tb/tb_sdp_fifo_m.sv
// tb/tb_sdp_fifo_m.sv - randomized scoreboard bench for sdp_fifo_m
module tb_sdp_fifo_m;

  localparam int DATA_W     = 32;
  localparam int DEPTH      = 512;
  localparam int RD_LATENCY = 2;
  localparam int OB_DEPTH   = RD_LATENCY + 1;
  localparam int CNT_W      = $clog2(DEPTH + OB_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  count;

  sdp_fifo_m #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_TYPE("block"), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the FIFO contents as a plain queue plus event logs
  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] pop_val [$];
  int                pop_edge [$];
  int                push_edge [$];
  int                ov_rise = -1;
  int                ir_rise = -1;
  bit                chk_en = 1'b0;
  bit                rst_prev = 1'b1;
  bit                m_push, m_pop;

  always @(negedge clk) begin
    if (chk_en) begin
      m_push = in_valid && in_ready;
      m_pop  = out_valid && out_ready;
      chk("count", 64'(count), 64'(model_q.size()));
      if (model_q.size() == 0) chk("out_valid_empty", 64'(out_valid), 64'd0);
      else if (out_valid) chk("out_data", 64'(out_data), 64'(model_q[0]));
      if (!rst_prev && model_q.size() < DEPTH) chk("in_ready_space", 64'(in_ready), 64'd1);
      if (model_q.size() == DEPTH + OB_DEPTH) chk("in_ready_full", 64'(in_ready), 64'd0);
      if (out_valid && ov_rise < 0) ov_rise = cyc;
      if (in_ready && ir_rise < 0) ir_rise = cyc;
      if (rst) model_q.delete();
      else begin
        if (m_pop) begin
          pop_val.push_back(out_data);
          pop_edge.push_back(cyc + 1);
          if (model_q.size() > 0) void'(model_q.pop_front());
        end
        if (m_push) begin
          model_q.push_back(in_data);
          push_edge.push_back(cyc + 1);
        end
      end
    end
    rst_prev = rst;
  end

  logic [DATA_W-1:0] next_word;
  bit                acc;
  int                n;

  task automatic step(input bit iv, input bit orr);
    in_valid  = iv;
    out_ready = orr;
    in_data   = next_word;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) next_word++;
  endtask

  task automatic drain(input string name, input int bound);
    int k = 0;
    while ((count != 0 || out_valid) && k < bound) begin
      step(1'b0, 1'b1);
      k++;
    end
    chk({name, "_drained"}, 64'(count), 64'd0);
  endtask

  task automatic clr();
    pop_val.delete();
    pop_edge.delete();
    push_edge.delete();
    ov_rise = -1;
    ir_rise = -1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: run exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; next_word = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_release_in_ready_high", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 8 words into an empty FIFO with the sink always ready
    clr(); next_word = 0; n = 0;
    for (int g = 0; g < 100 && n < 8; g++) begin step(1'b1, 1'b1); if (acc) n++; end
    drain("t1", 50);
    chk("t1_npop", 64'(pop_val.size()), 64'd8);
    if (pop_val.size() == 8 && push_edge.size() > 0) begin
      chk("t1_latency", 64'(ov_rise - push_edge[0]), 64'd3);
      for (int i = 0; i < 8; i++) chk("t1_data", 64'(pop_val[i]), 64'(i));
      chk("t1_spacing", 64'(pop_edge[7] - pop_edge[0]), 64'd7);
    end

    // Fill to capacity with the sink stalled, then drain
    clr(); next_word = 32'h100; n = 0;
    for (int g = 0; g < 2000; g++) begin step(1'b1, 1'b0); if (acc) n++; else break; end
    chk("t2_pushes", 64'(n), 64'd515);
    chk("t2_count_full", 64'(count), 64'd515);
    repeat (5) step(1'b0, 1'b0);
    chk("t2_in_ready_held", 64'(in_ready), 64'd0);
    clr();
    drain("t2", 2000);
    chk("t2_npop", 64'(pop_val.size()), 64'd515);
    if (pop_val.size() == 515) begin
      chk("t2_first", 64'(pop_val[0]), 64'h100);
      chk("t2_last", 64'(pop_val[514]), 64'h100 + 64'd514);
      chk("t2_ready_back", 64'(ir_rise), 64'(pop_edge[0]));
    end

    // 2000 words with random valid/ready at 50%
    clr(); next_word = 32'h1000; n = 0;
    for (int k = 0; k < 20000 && n < 2000; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (acc) n++;
    end
    chk("t3_pushes", 64'(n), 64'd2000);
    drain("t3", 3000);
    chk("t3_npop", 64'(pop_val.size()), 64'd2000);

    // Pre-fill, then 1000 cycles of push and pop together
    clr(); next_word = 32'h8000; n = 0;
    for (int g = 0; g < 200 && n < 64; g++) begin step(1'b1, 1'b0); if (acc) n++; end
    repeat (6) step(1'b0, 1'b0);
    chk("t4_fill", 64'(count), 64'd64);
    clr(); n = 0;
    for (int k = 0; k < 1000; k++) begin step(1'b1, 1'b1); if (acc) n++; end
    chk("t4_pushes", 64'(n), 64'd1000);
    chk("t4_pops", 64'(pop_val.size()), 64'd1000);
    chk("t4_count_steady", 64'(count), 64'd64);
    if (pop_val.size() > 0) chk("t4_first", 64'(pop_val[0]), 64'h8000);
    drain("t4", 200);

    // Three full pointer wraps at occupancy of one
    clr(); next_word = 32'h20000;
    for (int w = 0; w < 3 * DEPTH; w++) begin
      int g = 0;
      do begin step(1'b1, 1'b1); g++; end while (!acc && g < 10);
      drain("t5", 20);
    end
    chk("t5_npop", 64'(pop_val.size()), 64'(3 * DEPTH));
    if (pop_val.size() == 3 * DEPTH) chk("t5_last", 64'(pop_val[3*DEPTH-1]), 64'h20000 + 64'(3 * DEPTH - 1));

    // Reset with 100 words stored and reads in flight
    clr(); next_word = 32'h30000; n = 0;
    for (int g = 0; g < 300 && n < 100; g++) begin step(1'b1, 1'b0); if (acc) n++; end
    repeat (4) step(1'b0, 1'b0);
    chk("t6_stored", 64'(count), 64'd100);
    step(1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    clr(); next_word = 32'hA5; n = 0;
    for (int g = 0; g < 100 && n < 10; g++) begin step(1'b1, 1'b1); if (acc) n++; end
    drain("t6", 50);
    repeat (10) step(1'b0, 1'b1);
    chk("t6_npop", 64'(pop_val.size()), 64'd10);
    if (pop_val.size() == 10) begin
      for (int i = 0; i < 10; i++) chk("t6_data", 64'(pop_val[i]), 64'hA5 + 64'(i));
    end
    chk("t6_idle_out_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
